sprom_stream: RTL and testbench
===============================

# sprom_stream

Sequencer that sits directly downstream of the single-port ROM wrapper (SPXPM). It accepts a burst request (base address, word count), drives the ROM's enable/address port one word per cycle, and captures the 1-cycle-latency read data. It re-emits the captured data as a valid/ready stream with full backpressure support. It turns a latency-1, no-stall ROM port into a flow-controlled source for table-driven consumers (microcode, init sequences, constant tables).

## Interface
- `A`, 6, ROM address width; must match the attached ROM
- `D`, 32, ROM data width
- `clk`  in  1  clock; all state on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  burst request valid
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_base`  in  A  first ROM address of the burst
- `req_len`  in  A+1  word count, range 0..2**A
- `rom_en`  out  1  ROM read enable, to ROM `en`
- `rom_addr`  out  A  ROM read address, to ROM `addr` (registered)
- `rom_data`  in  D  ROM read data; valid the cycle after `rom_en`
- `out_valid`  out  1  stream beat valid
- `out_ready`  in  1  consumer ready
- `out_data`  out  D  stream beat data
- `busy`  out  1  high in RUN or DRAIN

## Operation
- **FSM states.** IDLE, RUN, DRAIN.
- **IDLE.**
  - `req_ready`=1.
  - On a handshake with `req_len`!=0: load the pointer to `req_base` and the remaining count to `req_len`, then go to RUN.
  - On a handshake with `req_len`==0: the request is consumed, no ROM reads occur, and the state stays IDLE.
- **RUN.**
  - `req_ready`=0.
  - `rom_en`=1 when remaining!=0 and (occupancy + inflight − pop) < 2.
    - occupancy: number of entries in the 2-entry output buffer.
    - inflight: 1 if `rom_en` was high in the previous cycle.
    - pop: `out_valid & out_ready`.
  - Each issue increments the pointer modulo 2**A (address 2**A−1 wraps to 0) and decrements remaining.
  - When the final issue happens (remaining goes 1→0), go to DRAIN.
- **Data capture.** When inflight=1, `rom_data` is written into the 2-entry FIFO that cycle. This write must never be dropped, and the credit rule guarantees it cannot overflow.
- **DRAIN.** No further reads. Go to IDLE on the edge where inflight=0 and the FIFO becomes empty, including the case where the last entry pops that cycle.
- **Output.** `out_valid` = FIFO non-empty; `out_data` = FIFO head. Data is delivered in address order.
- **Backpressure.** While `out_valid & !out_ready`, `out_data` holds stable and `out_valid` stays high.
- **No overlap.** Requests never overlap; `req_ready`=0 throughout RUN and DRAIN.
- **Reset values** (asserted or mid-operation, taking effect immediately):
  - state=IDLE, `req_ready`=1, `rom_en`=0, `rom_addr`=0, `out_valid`=0, `out_data`=0, `busy`=0
  - FIFO emptied, inflight cleared
  - Any ROM read outstanding at reset is discarded.

## Timing
- **Burst latency.** Request handshake in cycle C0:
  - C1: `rom_en`=1, `rom_addr`=base
  - C2: `rom_data` captured
  - C3: `out_valid`=1 with word[base]
- **Throughput.** With `out_ready` held high, one beat per cycle. A burst of length N delivers its last beat in C(N+2), and `req_ready` rises in C(N+3).
- **Stalled consumer.** With `out_ready` low, at most 2 words are buffered and at most 0 reads are in flight once the buffer is full. `rom_en` deasserts within 1 cycle of the FIFO reaching occupancy 2 minus in-flight.
- **Back-to-back bursts.** The next request's first beat appears 3 cycles after its acceptance. There is no bubble-free chaining across requests.

## Configuration
- `SPROM_STREAM_LAST_EN` compiled in:
  - Adds output port `out_last` (1 bit), high on the final beat of each burst.
  - A per-entry last flag is stored in the FIFO, set on the data captured from the issue where remaining went 1→0.
  - Reset value 0.
  - Valid only when `out_valid`=1.
- `SPROM_STREAM_LAST_EN` not defined: the `out_last` port and its storage do not exist. All other behaviour is identical.

## Test plan
The ROM is initialised with word[i] = 0xA000_0000 + i, A=6, D=32.

- **Basic burst, no backpressure.** `req_base`=5, `req_len`=4, `out_ready`=1 → `out_data` = 0xA0000005..0xA0000008 in C3..C6, with `out_last` high only in C6 (macro on). `req_ready` rises in C7.
- **Wrap-around.** `req_base`=62, `req_len`=4 → addresses 62, 63, 0, 1, giving data 0xA000003E, 0xA000003F, 0xA0000000, 0xA0000001.
- **Backpressure.** `req_len`=8, `out_ready` toggling 1,0,0,1,… (also random) → all 8 words are delivered exactly once, in order. `out_data` is stable during stalls. `rom_en` is never high while occupancy + inflight − pop ≥ 2.
- **Full-size and zero-length requests.**
  - `req_len`=64 → 64 beats covering every address once, then IDLE.
  - `req_len`=0 → handshake completes, with `rom_en` and `out_valid` never asserted and `busy` staying 0.
- **Reset mid-burst.** `req_len`=10, assert `rst` low after the 3rd beat → all outputs are at reset values immediately and no further beats appear. A new request (base=0, len=2) then yields 0xA0000000 and 0xA0000001 only.

Source files
------------

// File: rtl/sprom_stream.sv
// Burst sequencer for a latency-1 ROM port, re-emitting read data as a valid/ready stream.
// Optional `SPROM_STREAM_LAST_EN adds an out_last flag marking the final beat of each burst.
module sprom_stream #(
    parameter int unsigned A = 6,
    parameter int unsigned D = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [A-1:0] req_base,
    input  logic [A:0]   req_len,
    output logic         rom_en,
    output logic [A-1:0] rom_addr,
    input  logic [D-1:0] rom_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [D-1:0] out_data,
`ifdef SPROM_STREAM_LAST_EN
    output logic         out_last,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e         state_q, state_d;
    logic [A-1:0]   ptr_q, ptr_d;
    logic [A:0]     rem_q, rem_d;
    logic           inflight_q;
    logic [D-1:0]   mem_q [2];
    logic           wr_ptr_q, rd_ptr_q;
    logic [1:0]     count_q, count_d;
    logic           pop, push, issue;
    logic [2:0]     credit;

    assign pop    = out_valid & out_ready;
    assign push   = inflight_q;
    // Entries the buffer will hold after this cycle if nothing new is issued.
    assign credit = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        req_ready = 1'b0;
        issue     = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid && req_len != '0) begin
                    ptr_d   = req_base;
                    rem_d   = req_len;
                    state_d = StRun;
                end
            end
            StRun: begin
                issue = (rem_q != '0) && (credit < 3'd2);
                if (issue) begin
                    ptr_d = ptr_q + A'(1);
                    rem_d = rem_q - (A+1)'(1);
                    if (rem_q == (A+1)'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!inflight_q && (count_q == 2'd0 || (count_q == 2'd1 && pop))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign count_d   = count_q + {1'b0, push} - {1'b0, pop};
    assign rom_en    = issue;
    assign rom_addr  = ptr_q;
    assign busy      = (state_q != StIdle);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
            count_q    <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= rom_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

`ifdef SPROM_STREAM_LAST_EN
    logic last_q [2];
    logic inflight_last_q;

    assign out_last = last_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_last_q <= 1'b0;
            last_q[0]       <= 1'b0;
            last_q[1]       <= 1'b0;
        end else begin
            inflight_last_q <= issue && (rem_q == (A+1)'(1));
            if (push) begin
                last_q[wr_ptr_q] <= inflight_last_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sprom_stream.sv
// Scoreboard bench for sprom_stream with a behavioural latency-1 ROM holding 0xA000_0000 + addr.
module tb_sprom_stream;
    localparam int unsigned A = 6;
    localparam int unsigned D = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [A-1:0] req_base = '0;
    logic [A:0]   req_len = '0;
    logic         rom_en;
    logic [A-1:0] rom_addr;
    logic [D-1:0] rom_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [D-1:0] out_data;
    logic         busy;
`ifdef SPROM_STREAM_LAST_EN
    logic         out_last;
`endif

    sprom_stream #(.A(A), .D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_base  (req_base),
        .req_len   (req_len),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SPROM_STREAM_LAST_EN
        .out_last  (out_last),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'hA000_0000 + {26'b0, rom_addr};
    end

    typedef struct packed {
        logic         last;
        logic [D-1:0] data;
    } beat_t;

    beat_t        sb[$];
    beat_t        exp_beat;
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           mode = 0;
    int           pat = 0;
    int           hs_cyc = 0;
    int           beat_idx = 0;
    logic [A-1:0] hs_base = '0;
    logic [A:0]   hs_len = '0;
    int           occ = 0;
    logic         infl = 1'b0;
    int           pop_i;
    logic         stall_prev = 1'b0;
    logic [D-1:0] data_prev = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Out-ready pattern: 0 always ready, 1 repeating 1,0,0,1, 2 random.
    always @(posedge clk) begin
        #1;
        case (mode)
            1: begin
                out_ready = (pat == 0 || pat == 3);
                pat = (pat + 1) % 4;
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // Independent occupancy/inflight model for the credit rule.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ  <= 0;
            infl <= 1'b0;
        end else begin
            occ  <= occ + int'(infl) - int'(out_valid && out_ready);
            infl <= rom_en;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pop_i = int'(out_valid && out_ready);
            check("valid_vs_occ", out_valid, occ != 0);
            if (rom_en) check("credit", (occ + int'(infl) - pop_i) < 2, 1);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, data_prev);
            end
            if (req_valid && req_ready) begin
                hs_cyc   = cyc;
                hs_base  = req_base;
                hs_len   = req_len;
                beat_idx = 0;
            end
            if (mode == 0 && hs_len != 0 && cyc == hs_cyc + 1) begin
                check("c1_rom_en", rom_en, 1);
                check("c1_rom_addr", rom_addr, hs_base);
            end
            if (pop_i != 0) begin
                if (sb.size() == 0) begin
                    check("extra_beat", out_data, 0);
                end else begin
                    exp_beat = sb.pop_front();
                    check("data", out_data, exp_beat.data);
`ifdef SPROM_STREAM_LAST_EN
                    check("last", out_last, exp_beat.last);
`endif
                    if (mode == 0) check("beat_lat", cyc - hs_cyc, 3 + beat_idx);
                    beat_idx++;
                end
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_expected(input int base, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.last = (i == len - 1);
            b.data = 32'hA000_0000 + 32'((base + i) & 63);
            sb.push_back(b);
        end
    endtask

    task automatic send_req(input int base, input int len);
        @(posedge clk);
        #1;
        push_expected(base, len);
        req_base  = A'(base);
        req_len   = (A+1)'(len);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_burst(input int base, input int len);
        int k;
        send_req(base, len);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready && k < 2000);
        if (!req_ready) check("timeout_idle", 0, 1);
        else if (mode == 0 && len != 0) check("ready_rise", k, len + 3);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rom_en"}, rom_en, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
`ifdef SPROM_STREAM_LAST_EN
        check({tag, "_out_last"}, out_last, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b1;

        mode = 0;
        run_burst(5, 4);
        run_burst(62, 4);

        mode = 1;
        run_burst(20, 8);
        mode = 2;
        run_burst(40, 8);
        run_burst(60, 8);

        run_burst(17, 64);
        mode = 0;
        run_burst(0, 64);

        // Zero-length request: consumed without any activity.
        run_burst(9, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zl_rom_en", rom_en, 0);
            check("zl_out_valid", out_valid, 0);
            check("zl_busy", busy, 0);
            check("zl_req_ready", req_ready, 1);
        end

        // Reset after the third beat of a ten-word burst.
        send_req(30, 10);
        k = 0;
        while (beat_idx < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("mid_reached", beat_idx >= 3, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_busy", busy, 0);
        run_burst(0, 2);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
